// File: rtl/as_4bit.sv
// Registered ripple-carry adder/subtractor: {cout,s} = A + (B ^ {WIDTH{M}}) + M, one-cycle latency.
// Define AS4_OVF_EN to add the registered signed-overflow output v.

module as4_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));
endmodule

module as_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef AS4_OVF_EN
    ,
    output logic             v
`endif
);
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH:0]   c;

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;

    // Subtract is A + ~B + 1: invert B and inject M as the carry-in.
    assign b_x  = B ^ {WIDTH{M}};
    assign c[0] = M;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        as4_fa u_fa (
            .a   (A[i]),
            .b   (b_x[i]),
            .ci  (c[i]),
            .sum (sum_w[i]),
            .co  (c[i+1])
        );
    end

    always_comb begin
        s_d    = sum_w;
        cout_d = c[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

`ifdef AS4_OVF_EN
    logic v_d, v_q;

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    always_comb v_d = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= 1'b0;
        else     v_q <= v_d;
    end

    assign v = v_q;
`endif

endmodule

// File: tb/tb_as_4bit.sv
// Scoreboard bench for as_4bit: expected results queued at drive time, popped one edge later.
// Builds with or without AS4_OVF_EN.

module tb_as_4bit;
    logic       clk;
    logic       rst;
    logic [3:0] A, B;
    logic       M;
    logic [3:0] s;
    logic       cout;
`ifdef AS4_OVF_EN
    logic       v;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    as_4bit #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .M    (M),
        .s    (s),
        .cout (cout)
`ifdef AS4_OVF_EN
        ,
        .v    (v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [5:0] obs();
`ifdef AS4_OVF_EN
        return {v, cout, s};
`else
        return {1'b0, cout, s};
`endif
    endfunction

    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [4:0] r;
        int sa, sb, sr;
        logic ov;
        r  = {1'b0, a} + {1'b0, b ^ {4{m}}} + {4'b0, m};
        sa = $signed(a);
        sb = $signed(b);
        sr = m ? sa - sb : sa + sb;
        ov = (sr > 7) || (sr < -8);
`ifdef AS4_OVF_EN
        return {ov, r};
`else
        return {1'b0, r};
`endif
    endfunction

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one op, compare one edge later, then confirm nothing moved before the next edge.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [5:0] e;
        A = a; B = b; M = m;
        exp_q.push_back(model(a, b, m));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty_q"}, obs(), 6'h3f);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs(), e);
            @(negedge clk);
            chk({tag, "_hold"}, obs(), e);
        end
    endtask

    initial begin
        rst = 1'b1; A = 4'hF; B = 4'hF; M = 1'b0;
        #1;
        chk("rst_init", obs(), 6'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_hold", obs(), 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Add mode
        do_op("add_5_11", 4'b0101, 4'b1011, 1'b0);
        do_op("add_6_15", 4'b0110, 4'b1111, 1'b0);
        do_op("add_7_0",  4'b0111, 4'b0000, 1'b0);
        do_op("add_8_12", 4'b1000, 4'b1100, 1'b0);
        // Subtract mode
        do_op("sub_5_11", 4'b0101, 4'b1011, 1'b1);
        do_op("sub_6_15", 4'b0110, 4'b1111, 1'b1);
        do_op("sub_7_0",  4'b0111, 4'b0000, 1'b1);
        do_op("sub_eq",   4'b1011, 4'b1011, 1'b1);
        do_op("sub_9_14", 4'b1001, 4'b1110, 1'b1);
        // Overflow corners
        do_op("ovf_add",  4'b0111, 4'b0001, 1'b0);
        do_op("ovf_sub",  4'b1000, 4'b0001, 1'b1);
        do_op("novf_add", 4'b0100, 4'b1010, 1'b0);

        // Spot constants straight from the vector table (cout,s)
        A = 4'b1001; B = 4'b1110; M = 1'b1;
        @(posedge clk); #1;
        chk("const_sub_9_14", {2'b00, cout, s} & 6'h1f, 6'b0_01011);
        A = 4'b0110; B = 4'b1111; M = 1'b0;
        @(posedge clk); #1;
        chk("const_add_6_15", {2'b00, cout, s} & 6'h1f, 6'b1_0101);
        @(negedge clk);

        // Alternating M each cycle
        for (int i = 0; i < 16; i++)
            do_op("alt", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'(i & 1));

        // Async reset mid-cycle with a nonzero result showing
        A = 4'b0111; B = 4'b0000; M = 1'b0;
        @(posedge clk); #1;
        chk("pre_async", obs(), model(4'b0111, 4'b0000, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_clr", obs(), 6'b0);
        @(posedge clk); #1;
        chk("async_hold", obs(), 6'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", 4'b1100, 4'b0011, 1'b0);

        // Exhaustive sweep
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    do_op("exh", 4'(a), 4'(b), 1'(m));

        if (exp_q.size() != 0)
            chk("q_drained", 6'(exp_q.size()), 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
